// File: rtl/fpu_shared_unit_arbiter.sv
// fpu_shared_unit_arbiter
// Shares one pipelined FPU execution unit among NUM_REQ requesters. Issue slots
// are granted round-robin. A stalled grant is locked until its handshake
// completes. An in-order owner FIFO records who issued each operation so that
// unit results are routed back to the right requester.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   per-requester issue handshake
//   req_op/req_a/req_b    packed per-requester opcode and operands
//   unit_valid/ready      issue handshake toward the shared unit
//   unit_op/a/b           issued opcode and operands (combinational mux)
//   unit_resp_*           in-order result stream from the unit
//   resp_valid/ready      per-requester result handshake (valid is one-hot or zero)
//   resp_result           result payload, shared by all requesters
module fpu_shared_unit_arbiter #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned OP_WIDTH        = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned FLOAT_W        = 32,
    localparam int unsigned RESULT_W       = 41
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*OP_WIDTH-1:0]   req_op,
    input  logic [NUM_REQ*FLOAT_W-1:0]    req_a,
    input  logic [NUM_REQ*FLOAT_W-1:0]    req_b,
    output logic                          unit_valid,
    input  logic                          unit_ready,
    output logic [OP_WIDTH-1:0]           unit_op,
    output logic [FLOAT_W-1:0]            unit_a,
    output logic [FLOAT_W-1:0]            unit_b,
    input  logic                          unit_resp_valid,
    output logic                          unit_resp_ready,
    input  logic [RESULT_W-1:0]           unit_resp_result,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [RESULT_W-1:0]           resp_result
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t      r_state;
    lock_state_t      w_state_nxt;
    logic [IDX_W-1:0] r_lock_idx;
    logic [IDX_W-1:0] w_lock_idx_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_owner [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_found;
    logic [IDX_W-1:0] w_search_idx;
    logic             w_grant_any;
    logic [IDX_W-1:0] w_grant_idx;
    logic [IDX_W-1:0] w_next_rr;
    logic             w_issue_valid;
    logic             w_push;
    logic             w_pop;
    logic [IDX_W-1:0] w_head;

    assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_empty = (r_count == '0);
    assign w_head  = r_owner[r_rd_ptr];

    // Round-robin search: first valid requester at or after r_rr_ptr, wrapping.
    always_comb begin
        logic [IDX_W:0] cand;
        cand         = '0;
        w_found      = 1'b0;
        w_search_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_found && req_valid[cand[IDX_W-1:0]]) begin
                w_found      = 1'b1;
                w_search_idx = cand[IDX_W-1:0];
            end
        end
    end

    // A locked grant overrides the search until it completes its handshake.
    assign w_grant_any   = (r_state == ST_LOCKED) || w_found;
    assign w_grant_idx   = (r_state == ST_LOCKED) ? r_lock_idx : w_search_idx;
    assign w_next_rr     = (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + IDX_W'(1);
    assign w_issue_valid = rst_n && w_grant_any && !w_full;
    assign w_push        = w_issue_valid && unit_ready;

    // Issue path: zero-latency mux from the granted requester.
    always_comb begin
        unit_valid = w_issue_valid;
        unit_op    = req_op[int'(w_grant_idx)*OP_WIDTH +: OP_WIDTH];
        unit_a     = req_a[int'(w_grant_idx)*FLOAT_W +: FLOAT_W];
        unit_b     = req_b[int'(w_grant_idx)*FLOAT_W +: FLOAT_W];
        req_ready  = '0;
        if (w_push) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    // Response path: only the FIFO head owner may see or accept the result.
    always_comb begin
        resp_result     = unit_resp_result;
        resp_valid      = '0;
        unit_resp_ready = rst_n && !w_empty && resp_ready[w_head];
        if (rst_n && !w_empty && unit_resp_valid) begin
            resp_valid[w_head] = 1'b1;
        end
    end

    assign w_pop = unit_resp_valid && unit_resp_ready;

    // Grant lock: next-state logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_idx_nxt = r_lock_idx;
        case (r_state)
            ST_ARB: begin
                if (w_issue_valid && !unit_ready) begin
                    w_state_nxt    = ST_LOCKED;
                    w_lock_idx_nxt = w_grant_idx;
                end
            end
            ST_LOCKED: begin
                if (w_push) begin
                    w_state_nxt = ST_ARB;
                end
            end
            default: w_state_nxt = ST_ARB;
        endcase
    end

    // Lock state, round-robin pointer and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_ARB;
            r_lock_idx <= '0;
            r_rr_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_idx <= w_lock_idx_nxt;
            if (w_push) begin
                r_rr_ptr <= w_next_rr;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Owner storage; stale entries are harmless because pointers reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_owner[r_wr_ptr] <= w_grant_idx;
        end
    end

    // A result with no outstanding owner is a unit protocol violation.
    a_resp_without_owner : assert property (
        @(posedge clk) disable iff (!rst_n) !(unit_resp_valid && w_empty)
    );

endmodule

// File: tb/tb_fpu_shared_unit_arbiter.sv
module tb_fpu_shared_unit_arbiter;

    localparam int N    = 4;
    localparam int OPW  = 4;
    localparam int MAXO = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*OPW-1:0] req_op;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic            unit_valid;
    logic            unit_ready;
    logic [OPW-1:0]  unit_op;
    logic [31:0]     unit_a;
    logic [31:0]     unit_b;
    logic            unit_resp_valid;
    logic            unit_resp_ready;
    logic [40:0]     unit_resp_result;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic [40:0]     resp_result;

    always #5 clk = ~clk;

    fpu_shared_unit_arbiter #(
        .NUM_REQ(N), .OP_WIDTH(OPW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .unit_valid(unit_valid), .unit_ready(unit_ready),
        .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
        .unit_resp_valid(unit_resp_valid), .unit_resp_ready(unit_resp_ready),
        .unit_resp_result(unit_resp_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: owner queue, round-robin start, lock.
    int q_owner[$];
    int m_rr        = 0;
    bit m_locked    = 0;
    int m_lock_idx  = 0;

    logic         exp_uvalid;
    logic [N-1:0] exp_req_ready;
    logic [N-1:0] exp_resp_valid;
    logic         exp_urr;
    int           exp_grant;

    function automatic void compute_expect();
        bit found;
        int g;
        found = 0;
        g     = 0;
        if (m_locked) begin
            found = 1;
            g     = m_lock_idx;
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (!found && req_valid[c]) begin
                    found = 1;
                    g     = c;
                end
            end
        end
        exp_grant      = g;
        exp_uvalid     = rst_n && found && (q_owner.size() < MAXO);
        exp_req_ready  = '0;
        if (exp_uvalid && unit_ready) exp_req_ready[g] = 1'b1;
        exp_resp_valid = '0;
        exp_urr        = 1'b0;
        if (rst_n && q_owner.size() > 0) begin
            exp_urr = resp_ready[q_owner[0]];
            if (unit_resp_valid) exp_resp_valid[q_owner[0]] = 1'b1;
        end
    endfunction

    // Clock one cycle and update the model from the handshakes in this cycle.
    task automatic advance();
        bit push;
        bit pop;
        int g;
        compute_expect();
        push = exp_uvalid && unit_ready;
        pop  = unit_resp_valid && exp_urr;
        g    = exp_grant;
        @(posedge clk);
        if (!rst_n) begin
            q_owner.delete();
            m_rr     = 0;
            m_locked = 0;
        end else begin
            if (pop) void'(q_owner.pop_front());
            if (push) begin
                q_owner.push_back(g);
                m_rr     = (g + 1) % N;
                m_locked = 0;
            end else if (exp_uvalid) begin
                m_locked   = 1;
                m_lock_idx = g;
            end
        end
        #1;
    endtask

    task automatic set_defaults();
        req_valid        = '0;
        unit_ready       = 1'b0;
        unit_resp_valid  = 1'b0;
        unit_resp_result = '0;
        resp_ready       = '1;
        for (int i = 0; i < N; i++) begin
            req_op[i*OPW +: OPW] = OPW'(i + 1);
            req_a[i*32 +: 32]    = 32'hA000_0000 + 32'(i);
            req_b[i*32 +: 32]    = 32'hB000_0000 + 32'(i);
        end
    endtask

    task automatic do_reset();
        set_defaults();
        rst_n = 1'b0;
        advance();
        advance();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (unit_valid !== 1'b0) begin bad++; $display("FAIL reset_unit_valid: got %b want 0", unit_valid); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        total++; if (resp_valid !== 4'b0000) begin bad++; $display("FAIL reset_resp_valid: got %b want 0000", resp_valid); end
        total++; if (unit_resp_ready !== 1'b0) begin bad++; $display("FAIL reset_unit_resp_ready: got %b want 0", unit_resp_ready); end
        advance();
    endtask

    task automatic test_single();
        do_reset();
        req_valid         = 4'b0100;
        unit_ready        = 1'b1;
        req_op[8 +: 4]    = 4'h1;
        req_a[64 +: 32]   = 32'h3F80_0000;
        req_b[64 +: 32]   = 32'h4000_0000;
        @(negedge clk);
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_req_ready: got %b want 0100", req_ready); end
        total++; if (unit_a !== 32'h3F80_0000 || unit_b !== 32'h4000_0000 || unit_op !== 4'h1) begin
            bad++; $display("FAIL single_operands: got %h %h %h want 3f800000 40000000 1", unit_a, unit_b, unit_op); end
        advance();
        req_valid        = '0;
        unit_resp_valid  = 1'b1;
        unit_resp_result = 41'h0_4040_0000;
        @(negedge clk);
        total++; if (resp_valid !== 4'b0100) begin bad++; $display("FAIL single_resp_valid: got %b want 0100", resp_valid); end
        total++; if (resp_result !== 41'h0_4040_0000) begin bad++; $display("FAIL single_resp_result: got %h want 040400000", resp_result); end
        total++; if (unit_resp_ready !== 1'b1) begin bad++; $display("FAIL single_urr: got %b want 1", unit_resp_ready); end
        advance();
        unit_resp_valid = 1'b0;
        req_valid       = 4'b1111;
        unit_ready      = 1'b1;
        @(negedge clk);
        total++; if (unit_resp_ready !== 1'b0) begin bad++; $display("FAIL single_empty_urr: got %b want 0", unit_resp_ready); end
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL single_rr_next: got %b want 1000", req_ready); end
        advance();
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid  = 4'b1111;
        unit_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            logic [N-1:0] want_rv;
            unit_resp_valid  = (c >= 2);
            unit_resp_result = 41'(c);
            want_rv = (c >= 2) ? 4'(1 << ((c - 2) % N)) : 4'b0000;
            @(negedge clk);
            total++; if (req_ready !== 4'(1 << (c % N))) begin bad++; $display("FAIL rr_grant c=%0d: got %b want %b", c, req_ready, 4'(1 << (c % N))); end
            total++; if (resp_valid !== want_rv) begin bad++; $display("FAIL rr_resp c=%0d: got %b want %b", c, resp_valid, want_rv); end
            advance();
        end
    endtask

    task automatic test_lock();
        do_reset();
        req_valid  = 4'b1010;
        unit_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) req_valid[0] = 1'b1;
            @(negedge clk);
            total++; if (unit_valid !== 1'b1 || unit_a !== 32'hA000_0001) begin
                bad++; $display("FAIL lock_hold c=%0d: got v=%b a=%h want v=1 a=a0000001", c, unit_valid, unit_a); end
            total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL lock_ready c=%0d: got %b want 0000", c, req_ready); end
            advance();
        end
        unit_ready = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL lock_release: got %b want 0010", req_ready); end
        advance();
        req_valid[1] = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 4'b1000 || unit_a !== 32'hA000_0003) begin
            bad++; $display("FAIL lock_next: got %b a=%h want 1000 a=a0000003", req_ready, unit_a); end
        advance();
    endtask

    task automatic test_full();
        do_reset();
        req_valid  = 4'b1111;
        unit_ready = 1'b1;
        for (int c = 0; c < MAXO; c++) advance();
        @(negedge clk);
        total++; if (unit_valid !== 1'b0 || req_ready !== 4'b0000) begin
            bad++; $display("FAIL full_block: got v=%b r=%b want v=0 r=0000", unit_valid, req_ready); end
        advance();
        unit_resp_valid = 1'b1;
        @(negedge clk);
        total++; if (unit_valid !== 1'b0) begin bad++; $display("FAIL full_pop_same_cycle: got %b want 0", unit_valid); end
        total++; if (resp_valid !== 4'b0001 || unit_resp_ready !== 1'b1) begin
            bad++; $display("FAIL full_pop: got rv=%b urr=%b want 0001 1", resp_valid, unit_resp_ready); end
        advance();
        unit_resp_valid = 1'b0;
        @(negedge clk);
        total++; if (unit_valid !== 1'b1 || req_ready !== 4'b0001) begin
            bad++; $display("FAIL full_resume: got v=%b r=%b want 1 0001", unit_valid, req_ready); end
        advance();
    endtask

    task automatic test_backpressure();
        do_reset();
        unit_ready = 1'b1;
        req_valid  = 4'b0001;
        advance();
        req_valid  = 4'b0010;
        advance();
        req_valid       = '0;
        unit_resp_valid = 1'b1;
        resp_ready      = 4'b1110;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++; if (resp_valid !== 4'b0001 || unit_resp_ready !== 1'b0) begin
                bad++; $display("FAIL bp_stall c=%0d: got rv=%b urr=%b want 0001 0", c, resp_valid, unit_resp_ready); end
            advance();
        end
        resp_ready = 4'b0001;
        @(negedge clk);
        total++; if (unit_resp_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got %b want 1", unit_resp_ready); end
        advance();
        resp_ready = 4'b0011;
        @(negedge clk);
        total++; if (resp_valid !== 4'b0010) begin bad++; $display("FAIL bp_next_owner: got %b want 0010", resp_valid); end
        advance();
    endtask

    task automatic test_reset_midop();
        do_reset();
        unit_ready = 1'b1;
        req_valid  = 4'b0111;
        for (int c = 0; c < 3; c++) advance();
        req_valid  = 4'b1000;
        unit_ready = 1'b0;
        advance();
        rst_n = 1'b0;
        advance();
        rst_n     = 1'b1;
        req_valid = '0;
        @(negedge clk);
        total++; if (unit_valid !== 1'b0 || req_ready !== 4'b0000 || resp_valid !== 4'b0000 || unit_resp_ready !== 1'b0) begin
            bad++; $display("FAIL midop_outputs: got v=%b r=%b rv=%b urr=%b want all 0", unit_valid, req_ready, resp_valid, unit_resp_ready); end
        req_valid  = 4'b1111;
        unit_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL midop_rr_cleared: got %b want 0001", req_ready); end
        advance();
    endtask

    task automatic test_random();
        logic [31:0] lk_a;
        lk_a = '0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!(m_locked && i == m_lock_idx)) begin
                    req_op[i*OPW +: OPW] = OPW'($urandom);
                    req_a[i*32 +: 32]    = $urandom;
                    req_b[i*32 +: 32]    = $urandom;
                end
            end
            if (m_locked) req_valid[m_lock_idx] = 1'b1;
            unit_ready       = ($urandom_range(0, 2) != 0);
            unit_resp_valid  = (q_owner.size() > 0) ? 1'($urandom) : 1'b0;
            unit_resp_result = 41'({$urandom, $urandom});
            resp_ready       = N'($urandom);
            @(negedge clk);
            compute_expect();
            total++; if (unit_valid !== exp_uvalid) begin bad++; $display("FAIL rnd_unit_valid c=%0d: got %b want %b", c, unit_valid, exp_uvalid); end
            total++; if (req_ready !== exp_req_ready) begin bad++; $display("FAIL rnd_req_ready c=%0d: got %b want %b", c, req_ready, exp_req_ready); end
            total++; if (resp_valid !== exp_resp_valid) begin bad++; $display("FAIL rnd_resp_valid c=%0d: got %b want %b", c, resp_valid, exp_resp_valid); end
            total++; if (unit_resp_ready !== exp_urr) begin bad++; $display("FAIL rnd_urr c=%0d: got %b want %b", c, unit_resp_ready, exp_urr); end
            total++; if (resp_result !== unit_resp_result) begin bad++; $display("FAIL rnd_result c=%0d: got %h want %h", c, resp_result, unit_resp_result); end
            if (exp_uvalid) begin
                total++;
                if (unit_op !== req_op[exp_grant*OPW +: OPW] || unit_a !== req_a[exp_grant*32 +: 32] || unit_b !== req_b[exp_grant*32 +: 32]) begin
                    bad++; $display("FAIL rnd_operands c=%0d: got %h %h %h want %h %h %h", c, unit_op, unit_a, unit_b,
                        req_op[exp_grant*OPW +: OPW], req_a[exp_grant*32 +: 32], req_b[exp_grant*32 +: 32]);
                end
            end
            if (m_locked) begin
                total++; if (unit_a !== lk_a) begin bad++; $display("FAIL rnd_lock_stable c=%0d: got %h want %h", c, unit_a, lk_a); end
            end
            if (exp_uvalid && !unit_ready && !m_locked) lk_a = req_a[exp_grant*32 +: 32];
            advance();
        end
    endtask

    initial begin
        set_defaults();
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_full();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
